gxsim_qspi_frontend: RTL and testbench



---
 rtl/gxsim_qspi_frontend_pkg.sv | 38 +++
 rtl/gxsim_qspi_sync.sv | 28 ++
 rtl/gxsim_qspi_frontend.sv | 246 ++++++++++++++++++++++++
 tb/tb_gxsim_qspi_frontend.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/gxsim_qspi_frontend_pkg.sv
// Shared types and constants for the GenX QSPI slave front end.
package gxsim_qspi_frontend_pkg;

  // Frame decode states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_WDATA = 3'd3,
    ST_DUMMY = 3'd4,
    ST_RDATA = 3'd5,
    ST_HOLD  = 3'd6,
    ST_ERROR = 3'd7
  } qspi_state_e;

  // Active-high chip-select identities
  localparam logic [1:0] CS_HOST = 2'b10;
  localparam logic [1:0] CS_BANK = 2'b01;

  localparam int unsigned CMD_NIBBLES   = 2;
  localparam int unsigned ADDR_NIBBLES  = 8;
  localparam int unsigned WDATA_NIBBLES = 8;
  localparam int unsigned SCK_CNT_W     = 10;
  localparam int unsigned WORD_W        = 32;

  // Decoded frame payload handed to the handler
  typedef struct packed {
    logic              rw;
    logic [WORD_W-1:0] address;
    logic [WORD_W-1:0] wdata;
  } qspi_frame_t;

  // Saturating SCK edge counter increment
  function automatic logic [SCK_CNT_W-1:0] sat_inc(input logic [SCK_CNT_W-1:0] v);
    return (&v) ? v : v + SCK_CNT_W'(1);
  endfunction

endpackage

// File: rtl/gxsim_qspi_sync.sv
// 2-flop synchronizer with registered rise/fall strobes of the synchronized level.
module gxsim_qspi_sync (
  input  logic clk,
  input  logic resetn,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [2:0] sh_q;

  // Two sync stages plus one history stage; strobes registered one clk later
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sh_q <= 3'b000;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sh_q <= {sh_q[1:0], din};
      rise <= sh_q[1] & ~sh_q[2];
      fall <= ~sh_q[1] & sh_q[2];
    end
  end

  assign dout = sh_q[1];

endmodule

// File: rtl/gxsim_qspi_frontend.sv
// Oversampling QSPI slave front end: decodes command/address/write data and
// serializes handler read data back onto the IO lines.
module gxsim_qspi_frontend
  import gxsim_qspi_frontend_pkg::*;
#(
  parameter int unsigned SMEM_BW      = 512,
  parameter int unsigned DUMMY_CYCLES = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               qspi_sck,
  input  logic [1:0]         qspi_cs_n,
  input  logic [3:0]         qspi_io_in,
  output logic [3:0]         qspi_io_out,
  output logic               qspi_io_oe,
  output logic [9:0]         sck_counts,
  output logic               rw,
  output logic [31:0]        address,
  output logic [1:0]         cs_id,
  output logic [31:0]        wdata,
  input  logic [SMEM_BW-1:0] rdata,
  output logic               notify_read,
  output logic               notify_write
);

  localparam int unsigned NIB_TOTAL = SMEM_BW / 4;
  localparam int unsigned NIB_W     = $clog2(NIB_TOTAL) + 1;

  // Synchronized inputs and strobes
  logic       sck_level_unused;
  logic       sck_rise;
  logic       sck_fall;
  logic [1:0] cs_n_s;
  logic [1:0] cs_rise_unused;
  logic [1:0] cs_fall;
  logic [3:0] io_s1_q;
  logic [3:0] io_s2_q;

  gxsim_qspi_sync u_sync_sck (
    .clk    (clk),
    .resetn (resetn),
    .din    (qspi_sck),
    .dout   (sck_level_unused),
    .rise   (sck_rise),
    .fall   (sck_fall)
  );

  gxsim_qspi_sync u_sync_cs0 (
    .clk    (clk),
    .resetn (resetn),
    .din    (qspi_cs_n[0]),
    .dout   (cs_n_s[0]),
    .rise   (cs_rise_unused[0]),
    .fall   (cs_fall[0])
  );

  gxsim_qspi_sync u_sync_cs1 (
    .clk    (clk),
    .resetn (resetn),
    .din    (qspi_cs_n[1]),
    .dout   (cs_n_s[1]),
    .rise   (cs_rise_unused[1]),
    .fall   (cs_fall[1])
  );

  // Plain 2-flop synchronizer for the IO nibble
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      io_s1_q <= 4'h0;
      io_s2_q <= 4'h0;
    end else begin
      io_s1_q <= qspi_io_in;
      io_s2_q <= io_s1_q;
    end
  end

  logic [1:0] cs_act;
  logic       cs_start;
  logic       cs_idle;

  assign cs_act   = ~cs_n_s;
  // A falling cs_n edge is a fresh assertion; a CS held through reset never starts a frame
  assign cs_start = |cs_fall;
  assign cs_idle  = ~|cs_act;

  // Frame state and registered outputs
  qspi_state_e            state_q, state_d;
  logic [NIB_W-1:0]       nib_q, nib_d;
  logic [27:0]            in_sh_q, in_sh_d;
  logic [SMEM_BW-1:0]     rd_sh_q, rd_sh_d;
  qspi_frame_t            frame_q, frame_d;
  logic [1:0]             cs_id_q, cs_id_d;
  logic [SCK_CNT_W-1:0]   sck_cnt_q, sck_cnt_d;
  logic                   nr_q, nr_d;
  logic                   nw_q, nw_d;
  logic                   write_ok_q, write_ok_d;
  logic [3:0]             io_out_q, io_out_d;
  logic                   oe_q, oe_d;
  logic [WORD_W-1:0]      word_c;

  // Nibble just shifted in, completing a 32-bit word when the count is full
  assign word_c = {in_sh_q, io_s2_q};

  // State and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      nib_q      <= '0;
      in_sh_q    <= '0;
      rd_sh_q    <= '0;
      frame_q    <= '0;
      cs_id_q    <= 2'b00;
      sck_cnt_q  <= '0;
      nr_q       <= 1'b0;
      nw_q       <= 1'b0;
      write_ok_q <= 1'b0;
      io_out_q   <= 4'h0;
      oe_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      nib_q      <= nib_d;
      in_sh_q    <= in_sh_d;
      rd_sh_q    <= rd_sh_d;
      frame_q    <= frame_d;
      cs_id_q    <= cs_id_d;
      sck_cnt_q  <= sck_cnt_d;
      nr_q       <= nr_d;
      nw_q       <= nw_d;
      write_ok_q <= write_ok_d;
      io_out_q   <= io_out_d;
      oe_q       <= oe_d;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_d    = state_q;
    nib_d      = nib_q;
    in_sh_d    = in_sh_q;
    rd_sh_d    = rd_sh_q;
    frame_d    = frame_q;
    cs_id_d    = cs_id_q;
    sck_cnt_d  = sck_cnt_q;
    nr_d       = nr_q;
    nw_d       = nw_q;
    write_ok_d = write_ok_q;
    io_out_d   = io_out_q;
    oe_d       = oe_q;

    if (state_q == ST_IDLE) begin
      if (cs_start) begin
        cs_id_d    = cs_act;
        sck_cnt_d  = '0;
        nr_d       = 1'b0;
        nw_d       = 1'b0;
        write_ok_d = 1'b0;
        nib_d      = '0;
        state_d    = (&cs_act) ? ST_ERROR : ST_CMD;
      end
    end else if (cs_idle) begin
      // Release beats a coincident sck_rise; a partial nibble is dropped
      state_d = ST_IDLE;
      oe_d    = 1'b0;
      if (write_ok_q) begin
        nw_d       = 1'b1;
        write_ok_d = 1'b0;
      end
    end else begin
      if (sck_rise) begin
        sck_cnt_d = sat_inc(sck_cnt_q);
      end
      case (state_q)
        ST_CMD: begin
          if (sck_rise) begin
            in_sh_d = word_c[27:0];
            nib_d   = nib_q + NIB_W'(1);
            if (nib_q == NIB_W'(CMD_NIBBLES - 1)) begin
              frame_d.rw = word_c[7];
              nib_d      = '0;
              state_d    = ST_ADDR;
            end
          end
        end
        ST_ADDR: begin
          if (sck_rise) begin
            in_sh_d = word_c[27:0];
            nib_d   = nib_q + NIB_W'(1);
            if (nib_q == NIB_W'(ADDR_NIBBLES - 1)) begin
              frame_d.address = word_c;
              nr_d            = 1'b1;
              nib_d           = '0;
              state_d         = frame_q.rw ? ST_WDATA : ST_DUMMY;
            end
          end
        end
        ST_WDATA: begin
          if (sck_rise) begin
            in_sh_d = word_c[27:0];
            nib_d   = nib_q + NIB_W'(1);
            if (nib_q == NIB_W'(WDATA_NIBBLES - 1)) begin
              frame_d.wdata = word_c;
              write_ok_d    = 1'b1;
              nib_d         = '0;
              state_d       = ST_HOLD;
            end
          end
        end
        ST_DUMMY: begin
          if (sck_rise) begin
            nib_d = nib_q + NIB_W'(1);
            if (nib_q == NIB_W'(DUMMY_CYCLES - 1)) begin
              rd_sh_d = rdata;
              nib_d   = '0;
              state_d = ST_RDATA;
            end
          end
        end
        ST_RDATA: begin
          // Drive on fall; release the bus on the rise that samples the last nibble
          if (sck_fall && (nib_q < NIB_W'(NIB_TOTAL))) begin
            io_out_d = rd_sh_q[SMEM_BW-1 -: 4];
            rd_sh_d  = rd_sh_q << 4;
            oe_d     = 1'b1;
            nib_d    = nib_q + NIB_W'(1);
          end else if (sck_rise && (nib_q == NIB_W'(NIB_TOTAL))) begin
            oe_d    = 1'b0;
            state_d = ST_HOLD;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign qspi_io_out  = io_out_q;
  assign qspi_io_oe   = oe_q;
  assign sck_counts   = sck_cnt_q;
  assign rw           = frame_q.rw;
  assign address      = frame_q.address;
  assign cs_id        = cs_id_q;
  assign wdata        = frame_q.wdata;
  assign notify_read  = nr_q;
  assign notify_write = nw_q;

endmodule

// File: tb/tb_gxsim_qspi_frontend.sv
// Directed bench for the QSPI slave front end.
module tb_gxsim_qspi_frontend;

  localparam int unsigned SMEM_BW = 512;

  logic               clk = 1'b0;
  logic               resetn;
  logic               qspi_sck;
  logic [1:0]         qspi_cs_n;
  logic [3:0]         qspi_io_in;
  logic [3:0]         qspi_io_out;
  logic               qspi_io_oe;
  logic [9:0]         sck_counts;
  logic               rw;
  logic [31:0]        address;
  logic [1:0]         cs_id;
  logic [31:0]        wdata;
  logic [SMEM_BW-1:0] rdata;
  logic               notify_read;
  logic               notify_write;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  logic [3:0] cio;
  logic       coe;
  logic       oe_seen;

  gxsim_qspi_frontend #(.SMEM_BW(SMEM_BW), .DUMMY_CYCLES(4)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .qspi_sck     (qspi_sck),
    .qspi_cs_n    (qspi_cs_n),
    .qspi_io_in   (qspi_io_in),
    .qspi_io_out  (qspi_io_out),
    .qspi_io_oe   (qspi_io_oe),
    .sck_counts   (sck_counts),
    .rw           (rw),
    .address      (address),
    .cs_id        (cs_id),
    .wdata        (wdata),
    .rdata        (rdata),
    .notify_read  (notify_read),
    .notify_write (notify_write)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic waitclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCK period (16 clk); read-side outputs captured just before the rise
  task automatic sck_cycle(input logic [3:0] nib, output logic [3:0] c_io, output logic c_oe);
    qspi_io_in = nib;
    waitclk(8);
    c_io = qspi_io_out;
    c_oe = qspi_io_oe;
    qspi_sck = 1'b1;
    waitclk(8);
    qspi_sck = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int n);
    logic [3:0] d_io;
    logic       d_oe;
    for (int i = 0; i < n; i++) begin
      sck_cycle(4'(w >> (28 - 4 * i)), d_io, d_oe);
    end
  endtask

  task automatic cs_on(input logic [1:0] v);
    qspi_cs_n = v;
    waitclk(8);
  endtask

  task automatic cs_off();
    qspi_cs_n = 2'b11;
    waitclk(10);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_io_out"}, 32'(qspi_io_out), 32'h0);
    check({pfx, "_io_oe"}, 32'(qspi_io_oe), 32'h0);
    check({pfx, "_sck_counts"}, 32'(sck_counts), 32'h0);
    check({pfx, "_rw"}, 32'(rw), 32'h0);
    check({pfx, "_address"}, address, 32'h0);
    check({pfx, "_cs_id"}, 32'(cs_id), 32'h0);
    check({pfx, "_wdata"}, wdata, 32'h0);
    check({pfx, "_notify_read"}, 32'(notify_read), 32'h0);
    check({pfx, "_notify_write"}, 32'(notify_write), 32'h0);
  endtask

  // Safety net against a stuck run
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn     = 1'b0;
    qspi_sck   = 1'b0;
    qspi_cs_n  = 2'b11;
    qspi_io_in = 4'h0;
    rdata      = {32'h1234_5678, {(SMEM_BW - 32){1'b0}}};
    waitclk(4);
    check_all_zero("reset");
    resetn = 1'b1;
    waitclk(4);

    // Host write
    cs_on(2'b01);
    send_word(32'h8000_0000, 2);
    send_word(32'h0000_0010, 8);
    waitclk(4);
    check("wr_notify_read", 32'(notify_read), 32'h1);
    check("wr_cs_id", 32'(cs_id), 32'(2'b10));
    check("wr_rw", 32'(rw), 32'h1);
    check("wr_nw_early", 32'(notify_write), 32'h0);
    send_word(32'hDEAD_BEEF, 8);
    waitclk(4);
    check("wr_sck_counts", 32'(sck_counts), 32'd18);
    check("wr_wdata", wdata, 32'hDEAD_BEEF);
    check("wr_nw_before_release", 32'(notify_write), 32'h0);
    cs_off();
    check("wr_notify_write", 32'(notify_write), 32'h1);
    check("wr_address", address, 32'h0000_0010);

    // Host read, 128 nibbles
    cs_on(2'b01);
    check("rd_nr_cleared", 32'(notify_read), 32'h0);
    check("rd_nw_cleared", 32'(notify_write), 32'h0);
    send_word(32'h0000_0000, 2);
    send_word(32'h0000_0004, 8);
    waitclk(4);
    check("rd_notify_read", 32'(notify_read), 32'h1);
    check("rd_rw", 32'(rw), 32'h0);
    check("rd_address", address, 32'h0000_0004);
    for (int i = 0; i < 4; i++) begin
      sck_cycle(4'h0, cio, coe);
      check("rd_dummy_oe", 32'(coe), 32'h0);
    end
    for (int i = 0; i < 128; i++) begin
      sck_cycle(4'h0, cio, coe);
      check("rd_nibble", 32'(cio), (i < 8) ? 32'(i + 1) : 32'h0);
      check("rd_oe", 32'(coe), 32'h1);
    end
    waitclk(4);
    check("rd_oe_after", 32'(qspi_io_oe), 32'h0);
    check("rd_sck_counts", 32'(sck_counts), 32'd142);
    cs_off();
    check("rd_notify_write", 32'(notify_write), 32'h0);

    // Truncated write
    cs_on(2'b01);
    send_word(32'h8000_0000, 2);
    send_word(32'h0000_0020, 8);
    send_word(32'hCAFE_F00D, 5);
    cs_off();
    check("tr_wdata", wdata, 32'hDEAD_BEEF);
    check("tr_notify_write", 32'(notify_write), 32'h0);
    check("tr_address", address, 32'h0000_0020);
    check("tr_notify_read", 32'(notify_read), 32'h1);

    // Both chip-selects active
    cs_on(2'b00);
    check("both_cs_id", 32'(cs_id), 32'(2'b11));
    oe_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      sck_cycle(4'h8, cio, coe);
      oe_seen = oe_seen | coe;
    end
    check("both_oe", 32'(oe_seen), 32'h0);
    check("both_notify_read", 32'(notify_read), 32'h0);
    check("both_sck_counts", 32'(sck_counts), 32'd12);
    cs_off();
    check("both_notify_write", 32'(notify_write), 32'h0);
    check("both_cs_id_hold", 32'(cs_id), 32'(2'b11));

    // Reset pulsed mid-address
    cs_on(2'b10);
    send_word(32'h8000_0000, 2);
    send_word(32'hABCD_0123, 3);
    resetn = 1'b0;
    waitclk(2);
    check_all_zero("midrst");
    resetn = 1'b1;
    waitclk(4);
    send_word(32'h0123_4567, 5);
    check("midrst_no_count", 32'(sck_counts), 32'h0);
    check("midrst_no_nr", 32'(notify_read), 32'h0);
    cs_off();

    // Full bank write after reset, then an oversized frame in HOLD
    cs_on(2'b10);
    send_word(32'h8000_0000, 2);
    send_word(32'hABCD_0123, 8);
    send_word(32'h0123_4567, 8);
    waitclk(4);
    check("bank_cs_id", 32'(cs_id), 32'(2'b01));
    check("bank_address", address, 32'hABCD_0123);
    check("bank_wdata", wdata, 32'h0123_4567);
    check("bank_notify_read", 32'(notify_read), 32'h1);
    check("bank_sck_counts", 32'(sck_counts), 32'd18);
    for (int i = 0; i < 1100; i++) begin
      sck_cycle(4'hF, cio, coe);
    end
    waitclk(4);
    check("ovr_sck_counts", 32'(sck_counts), 32'd1023);
    check("ovr_address", address, 32'hABCD_0123);
    check("ovr_wdata", wdata, 32'h0123_4567);
    check("ovr_rw", 32'(rw), 32'h1);
    check("ovr_oe", 32'(qspi_io_oe), 32'h0);
    check("ovr_nw", 32'(notify_write), 32'h0);
    cs_off();
    check("ovr_notify_write", 32'(notify_write), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
